dmem_test_master: RTL and testbench

Initiator-side sequencer for the single-cycle data memory port (Mem_Addr/M_W_Data/M_R_Data/Mem_Write). On a start pulse it writes a fixed 4-entry pattern set to consecutive word addresses, reads every word back, compares, and reports pass/fail plus a byte of the last read word on the board LEDs. It sits between the board switches/buttons and the data memory in the FPGA bring-up build, replacing the CPU as the memory master.

---
 rtl/dmem_test_pkg.sv | 27 ++
 rtl/dmem_byte_sel.sv | 24 ++
 rtl/dmem_test_master.sv | 144 ++++++++++++++
 tb/tb_dmem_test_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_test_pkg.sv
// dmem_test_pkg
//   Shared types and constants for the data-memory test master:
//   sequencer state encoding, the 4-entry base pattern table and the
//   per-index pattern function.
package dmem_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] PAT [0:3] = '{
        32'h1111_2222,
        32'h3333_6666,
        32'h5555_8888,
        32'haaaa_ffff
    };

    // XOR-ing in the index makes every word of a 64-word run unique, so
    // aliased or stuck address lines show up as data mismatches.
    function automatic logic [31:0] pat(input logic [5:0] i);
        return PAT[i[1:0]] ^ {26'b0, i};
    endfunction

endpackage

// File: rtl/dmem_byte_sel.sv
// dmem_byte_sel
//   Selects one byte of a 32-bit word for display.
//   Ports:
//     word     in  32  source word
//     Choose   in  2   00=[7:0], 01=[15:8], 10=[23:16], 11=[31:24]
//     sel_byte out 8   selected byte (combinational)
module dmem_byte_sel (
    input  logic [31:0] word,
    input  logic [1:0]  Choose,
    output logic [7:0]  sel_byte
);

    always_comb begin
        sel_byte = '0;
        case (Choose)
            2'b00: sel_byte = word[7:0];
            2'b01: sel_byte = word[15:8];
            2'b10: sel_byte = word[23:16];
            2'b11: sel_byte = word[31:24];
            default: sel_byte = '0;
        endcase
    end

endmodule

// File: rtl/dmem_test_master.sv
// dmem_test_master
//   Memory-master sequencer for FPGA bring-up. A start pulse writes
//   N_WORDS pattern words to consecutive word addresses from BASE_ADDR
//   (wrapping mod 64), reads them back, compares each against its
//   pattern and reports the result.
//   Ports:
//     clk        in   1   system clock, rising edge
//     rst        in   1   asynchronous active-high reset
//     start      in   1   run request (ignored while busy)
//     Choose     in   2   LED byte select
//     M_R_Data   in   32  memory read data (combinational on Mem_Addr)
//     Mem_Addr   out  6   word address
//     M_W_Data   out  32  write data
//     Mem_Write  out  1   write enable
//     LED        out  8   selected byte of last read word
//     busy       out  1   high while writing or reading
//     done       out  1   high after a run completes
//     error      out  1   sticky mismatch flag for the current run
//     err_cnt    out  7   mismatching words this run (saturates at 64)
module dmem_test_master
    import dmem_test_pkg::*;
#(
    parameter logic [5:0]  BASE_ADDR = 6'd0,
    parameter int unsigned N_WORDS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  Choose,
    input  logic [31:0] M_R_Data,
    output logic [5:0]  Mem_Addr,
    output logic [31:0] M_W_Data,
    output logic        Mem_Write,
    output logic [7:0]  LED,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [6:0]  err_cnt
);

    localparam logic [5:0] LAST    = 6'(N_WORDS - 1);
    localparam logic [6:0] ERR_MAX = 7'd64;

    state_t      state, state_nxt;
    logic [5:0]  idx, idx_nxt;
    logic [31:0] rd_word, rd_word_nxt;
    logic        error_nxt;
    logic [6:0]  err_cnt_nxt;
    logic [5:0]  addr_nxt;
    logic [31:0] wdata_nxt;
    logic        we_nxt, busy_nxt, done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            rd_word   <= '0;
            error     <= 1'b0;
            err_cnt   <= '0;
            Mem_Addr  <= '0;
            M_W_Data  <= '0;
            Mem_Write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rd_word   <= rd_word_nxt;
            error     <= error_nxt;
            err_cnt   <= err_cnt_nxt;
            Mem_Addr  <= addr_nxt;
            M_W_Data  <= wdata_nxt;
            Mem_Write <= we_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        rd_word_nxt = rd_word;
        error_nxt   = error;
        err_cnt_nxt = err_cnt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = WRITE;
                    idx_nxt     = '0;
                    error_nxt   = 1'b0;
                    err_cnt_nxt = '0;
                end
            end
            WRITE: begin
                if (idx == LAST) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 6'd1;
                end
            end
            READ: begin
                rd_word_nxt = M_R_Data;
                if (M_R_Data != pat(idx)) begin
                    error_nxt = 1'b1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt_nxt = err_cnt + 7'd1;
                    end
                end
                if (idx == LAST) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 6'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Bus outputs are registered, so they are derived from the state and
        // index being entered; the memory then sees them for a full cycle.
        we_nxt    = (state_nxt == WRITE);
        busy_nxt  = (state_nxt == WRITE) || (state_nxt == READ);
        done_nxt  = (state_nxt == DONE);
        addr_nxt  = '0;
        wdata_nxt = '0;
        case (state_nxt)
            WRITE: begin
                addr_nxt  = BASE_ADDR + idx_nxt;
                wdata_nxt = pat(idx_nxt);
            end
            READ:    addr_nxt = BASE_ADDR + idx_nxt;
            DONE:    addr_nxt = Mem_Addr;
            default: addr_nxt = '0;
        endcase
    end

    dmem_byte_sel u_byte_sel (
        .word     (rd_word),
        .Choose   (Choose),
        .sel_byte (LED)
    );

endmodule

// File: tb/tb_dmem_test_master.sv
// tb_dmem_test_master
//   Three configurations of the test master, each paired with a 64x32
//   behavioral memory (posedge write, combinational read). Expected writes
//   and run results are queued when a run is issued; per-instance monitors
//   pop and compare whenever the DUT drives a write or raises done.
module tb_dmem_test_master;

    typedef struct packed { logic [5:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic err; logic [6:0] cnt; logic [7:0] led; } res_t;

    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic mem_clr = 1'b1;

    // instance 0: BASE_ADDR=0, N_WORDS=4
    logic rst0 = 1'b1, start0 = 1'b0, stuck0 = 1'b0;
    logic [1:0] ch0 = 2'b11;
    logic [31:0] rd0, wd0;
    logic [5:0] a0;
    logic we0, busy0, done0, err0;
    logic [7:0] led0;
    logic [6:0] cnt0;
    logic [31:0] mem0 [64];
    wr_t wq0[$];
    res_t rq0[$];

    // instance 1: BASE_ADDR=3E, N_WORDS=4
    logic rst1 = 1'b1, start1 = 1'b0;
    logic [1:0] ch1 = 2'b11;
    logic [31:0] rd1, wd1;
    logic [5:0] a1;
    logic we1, busy1, done1, err1;
    logic [7:0] led1;
    logic [6:0] cnt1;
    logic [31:0] mem1 [64];
    wr_t wq1[$];
    res_t rq1[$];

    // instance 2: BASE_ADDR=0, N_WORDS=64, read data corrupted
    logic rst2 = 1'b1, start2 = 1'b0, corrupt2 = 1'b0;
    logic [1:0] ch2 = 2'b00;
    logic [31:0] rd2, wd2;
    logic [5:0] a2;
    logic we2, busy2, done2, err2;
    logic [7:0] led2;
    logic [6:0] cnt2;
    logic [31:0] mem2 [64];
    wr_t wq2[$];
    res_t rq2[$];

    dmem_test_master #(.BASE_ADDR(6'd0), .N_WORDS(4)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .Choose(ch0), .M_R_Data(rd0),
        .Mem_Addr(a0), .M_W_Data(wd0), .Mem_Write(we0), .LED(led0),
        .busy(busy0), .done(done0), .error(err0), .err_cnt(cnt0)
    );

    dmem_test_master #(.BASE_ADDR(6'h3E), .N_WORDS(4)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .Choose(ch1), .M_R_Data(rd1),
        .Mem_Addr(a1), .M_W_Data(wd1), .Mem_Write(we1), .LED(led1),
        .busy(busy1), .done(done1), .error(err1), .err_cnt(cnt1)
    );

    dmem_test_master #(.BASE_ADDR(6'd0), .N_WORDS(64)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .Choose(ch2), .M_R_Data(rd2),
        .Mem_Addr(a2), .M_W_Data(wd2), .Mem_Write(we2), .LED(led2),
        .busy(busy2), .done(done2), .error(err2), .err_cnt(cnt2)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int j = 0; j < 64; j++) begin
                mem0[j] <= SENT;
                mem1[j] <= SENT;
                mem2[j] <= SENT;
            end
        end else begin
            if (we0) mem0[a0] <= wd0;
            if (we1) mem1[a1] <= wd1;
            if (we2) mem2[a2] <= wd2;
        end
    end

    // instance 0 fault: address 2 data bit 1 stuck at 0 on read
    assign rd0 = (stuck0 && a0 == 6'd2) ? (mem0[a0] & ~32'h2) : mem0[a0];
    assign rd1 = mem1[a1];
    assign rd2 = corrupt2 ? ~mem2[a2] : mem2[a2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    function automatic logic [31:0] tpat(input int i);
        logic [31:0] pt [4];
        pt = '{32'h1111_2222, 32'h3333_6666, 32'h5555_8888, 32'haaaa_ffff};
        return pt[i % 4] ^ 32'(i);
    endfunction

    // ---------------- monitors ----------------
    logic d0q = 1'b0, d1q = 1'b0, d2q = 1'b0;

    always @(negedge clk) begin
        if (we0) begin
            if (wq0.size() == 0) begin
                n_chk++;
                $display("FAIL wr0_extra: got write %h<=%h required none", a0, wd0);
            end else chk("wr0", {a0, wd0}, wq0.pop_front());
        end
        if (done0 && !d0q) begin
            if (rq0.size() == 0) begin
                n_chk++;
                $display("FAIL res0_extra: got done required none");
            end else chk("res0", {err0, cnt0, led0}, rq0.pop_front());
        end
        d0q <= done0;
    end

    always @(negedge clk) begin
        if (we1) begin
            if (wq1.size() == 0) begin
                n_chk++;
                $display("FAIL wr1_extra: got write %h<=%h required none", a1, wd1);
            end else chk("wr1", {a1, wd1}, wq1.pop_front());
        end
        if (done1 && !d1q) begin
            if (rq1.size() == 0) begin
                n_chk++;
                $display("FAIL res1_extra: got done required none");
            end else chk("res1", {err1, cnt1, led1}, rq1.pop_front());
        end
        d1q <= done1;
    end

    always @(negedge clk) begin
        if (we2) begin
            if (wq2.size() == 0) begin
                n_chk++;
                $display("FAIL wr2_extra: got write %h<=%h required none", a2, wd2);
            end else chk("wr2", {a2, wd2}, wq2.pop_front());
        end
        if (done2 && !d2q) begin
            if (rq2.size() == 0) begin
                n_chk++;
                $display("FAIL res2_extra: got done required none");
            end else chk("res2", {err2, cnt2, led2}, rq2.pop_front());
        end
        d2q <= done2;
    end

    // ---------------- stimulus ----------------
    // Issues a start on instance 0, optionally re-pulses start at edge count
    // pulse_at, and returns the number of edges from start sample to done.
    task automatic run0(input int pulse_at, output int cyc);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        chk("start0", {busy0, done0, err0, cnt0}, {1'b1, 1'b0, 1'b0, 7'd0});
        while (!done0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start0 = (cyc == pulse_at);
        end
        start0 = 1'b0;
    endtask

    task automatic push_run0();
        logic [31:0] exp4 [4];
        exp4 = '{32'h1111_2222, 32'h3333_6667, 32'h5555_888A, 32'haaaa_fffC};
        for (int i = 0; i < 4; i++) wq0.push_back({6'(i), exp4[i]});
    endtask

    initial begin
        int cyc;
        logic [31:0] exp4 [4];
        logic [5:0]  adr1 [4];
        exp4 = '{32'h1111_2222, 32'h3333_6667, 32'h5555_888A, 32'haaaa_fffC};
        adr1 = '{6'h3E, 6'h3F, 6'h00, 6'h01};

        repeat (3) @(negedge clk);
        chk("reset0", {a0, wd0, we0, led0, busy0, done0, err0, cnt0}, '0);
        chk("reset2", {a2, wd2, we2, led2, busy2, done2, err2, cnt2}, '0);
        mem_clr = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        repeat (2) @(negedge clk);

        // run 1: clean pass, LED byte selection
        push_run0();
        rq0.push_back({1'b0, 7'd0, 8'hAA});
        run0(0, cyc);
        chk("lat0", 64'(cyc), 64'd9);
        #2 ch0 = 2'b00; #1 chk("led_b0", led0, 8'hFC);
        ch0 = 2'b01;    #1 chk("led_b1", led0, 8'hFF);
        ch0 = 2'b10;    #1 chk("led_b2", led0, 8'hAA);
        ch0 = 2'b11;    #1 chk("led_b3", led0, 8'hAA);
        @(negedge clk);

        // run 2: stuck bit at address 2, start re-pulsed during READ
        stuck0 = 1'b1;
        push_run0();
        rq0.push_back({1'b1, 7'd1, 8'hAA});
        run0(6, cyc);
        chk("lat0_rdstart", 64'(cyc), 64'd9);
        @(negedge clk);
        chk("done_hold", {done0, busy0, we0, a0}, {1'b1, 1'b0, 1'b0, 6'd3});

        // run 3: start from DONE clears error state
        stuck0 = 1'b0;
        push_run0();
        rq0.push_back({1'b0, 7'd0, 8'hAA});
        run0(0, cyc);
        chk("lat0_redo", 64'(cyc), 64'd9);
        @(negedge clk);

        // asynchronous reset during the second write cycle
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
        wq0.push_back({6'd0, exp4[0]});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        #1 chk("pre_rst", {we0, a0}, {1'b1, 6'd1});
        #1 rst0 = 1'b1;
        #1 chk("rst_async", {a0, wd0, we0, led0, busy0, done0, err0, cnt0}, '0);
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        chk("rst_mem0", mem0[0], exp4[0]);
        chk("rst_mem1", mem0[1], SENT);
        chk("rst_mem2", mem0[2], SENT);
        chk("rst_idle", {busy0, done0, we0}, 3'b000);

        // instance 1: address wrap past 6'h3F
        for (int i = 0; i < 4; i++) wq1.push_back({adr1[i], exp4[i]});
        rq1.push_back({1'b0, 7'd0, 8'hAA});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 400) begin @(negedge clk); cyc++; end
        chk("lat1", 64'(cyc), 64'd9);
        chk("wrap_mem3e", mem1[6'h3E], exp4[0]);
        chk("wrap_mem01", mem1[6'h01], exp4[3]);
        chk("wrap_mem02", mem1[6'h02], SENT);

        // instance 2: 64 words, every read corrupted -> saturating count
        corrupt2 = 1'b1;
        for (int i = 0; i < 64; i++) wq2.push_back({6'(i), tpat(i)});
        rq2.push_back({1'b1, 7'd64, 8'h3F});
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 400) begin @(negedge clk); cyc++; end
        chk("lat2", 64'(cyc), 64'd129);
        repeat (2) @(negedge clk);
        chk("cnt2_hold", cnt2, 7'd64);

        chk("wq0_empty", 64'(wq0.size()), 64'd0);
        chk("rq0_empty", 64'(rq0.size()), 64'd0);
        chk("wq1_empty", 64'(wq1.size()), 64'd0);
        chk("rq1_empty", 64'(rq1.size()), 64'd0);
        chk("wq2_empty", 64'(wq2.size()), 64'd0);
        chk("rq2_empty", 64'(rq2.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
